ensemble_vote_collector: RTL

- Sink end of the three-classifier ensemble. Consumes the three AXI-Stream prediction streams (Gaussian NB, logistic regression, gradient boost) and holds one beat per lane.
- Once all three lanes hold a beat, it takes a majority vote and emits one AXI-Stream result beat toward the DMA.
- Also keeps result and disagreement counters for host readout.

---
 rtl/ensemble_pkg.sv | 14 +
 rtl/ensemble_lane_holder.sv | 63 ++++++
 rtl/ensemble_vote_collector.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/ensemble_pkg.sv
// Shared types and field constants for the three-lane ensemble vote collector.
package ensemble_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    VOTE    = 2'd1,
    SEND    = 2'd2
  } state_e;

  localparam int VOTE_CNT_LSB = 16;
  localparam int VOTE_CNT_W   = 2;
  localparam int NUM_LANES    = 3;

endpackage

// File: rtl/ensemble_lane_holder.sv
// One-entry holding buffer for a single prediction lane; refills only after an explicit clear.
module ensemble_lane_holder
  import ensemble_pkg::*;
#(
  parameter int CLASS_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear_i,
  input  logic                   valid_i,
  input  logic [CLASS_WIDTH-1:0] label_i,
  input  logic                   last_i,
  output logic                   ready_o,
  output logic                   full_o,
  output logic                   full_next_o,
  output logic [CLASS_WIDTH-1:0] label_o,
  output logic                   last_o
);

  logic                   full_q, full_d;
  logic [CLASS_WIDTH-1:0] label_q, label_d;
  logic                   last_q, last_d;
  logic                   capture_s;

  // Ready is forced low while reset is held so nothing is accepted during reset.
  assign ready_o = rst_n & ~full_q;

  // Capture / clear decision for the single entry.
  always_comb begin
    capture_s = valid_i & ready_o;
    full_d    = full_q;
    label_d   = label_q;
    last_d    = last_q;
    if (clear_i) begin
      full_d = 1'b0;
    end else if (capture_s) begin
      full_d  = 1'b1;
      label_d = label_i;
      last_d  = last_i;
    end else begin
      full_d = full_q;
    end
  end

  // Entry storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q  <= 1'b0;
      label_q <= {CLASS_WIDTH{1'b0}};
      last_q  <= 1'b0;
    end else begin
      full_q  <= full_d;
      label_q <= label_d;
      last_q  <= last_d;
    end
  end

  assign full_o      = full_q;
  assign full_next_o = full_d;
  assign label_o     = label_q;
  assign last_o      = last_q;

endmodule

// File: rtl/ensemble_vote_collector.sv
// Collects one prediction per classifier lane, majority-votes them and streams the result
// with delivered / disagreement counters and a sticky tlast-mismatch flag.
module ensemble_vote_collector
  import ensemble_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int KEEP_WIDTH  = 4,
  parameter int CLASS_WIDTH = 8,
  parameter int TIE_SEL     = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata_0,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_0,
  input  logic                  s_axis_tvalid_0,
  output logic                  s_axis_tready_0,
  input  logic                  s_axis_tlast_0,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata_1,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_1,
  input  logic                  s_axis_tvalid_1,
  output logic                  s_axis_tready_1,
  input  logic                  s_axis_tlast_1,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata_2,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_2,
  input  logic                  s_axis_tvalid_2,
  output logic                  s_axis_tready_2,
  input  logic                  s_axis_tlast_2,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [31:0]           result_count,
  output logic [15:0]           disagree_count,
  output logic                  tlast_mismatch
);

  logic [NUM_LANES-1:0]   valid_s, in_last_s, ready_s, full_s, full_next_s, last_s;
  logic [CLASS_WIDTH-1:0] in_label_s [NUM_LANES];
  logic [CLASS_WIDTH-1:0] label_s    [NUM_LANES];
  logic                   clear_s;
  logic                   unused_s;

  assign valid_s       = {s_axis_tvalid_2, s_axis_tvalid_1, s_axis_tvalid_0};
  assign in_last_s     = {s_axis_tlast_2, s_axis_tlast_1, s_axis_tlast_0};
  assign in_label_s[0] = s_axis_tdata_0[CLASS_WIDTH-1:0];
  assign in_label_s[1] = s_axis_tdata_1[CLASS_WIDTH-1:0];
  assign in_label_s[2] = s_axis_tdata_2[CLASS_WIDTH-1:0];
  assign unused_s      = ^{s_axis_tkeep_0, s_axis_tkeep_1, s_axis_tkeep_2,
                           s_axis_tdata_0[DATA_WIDTH-1:CLASS_WIDTH],
                           s_axis_tdata_1[DATA_WIDTH-1:CLASS_WIDTH],
                           s_axis_tdata_2[DATA_WIDTH-1:CLASS_WIDTH]};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    ensemble_lane_holder #(
      .CLASS_WIDTH (CLASS_WIDTH)
    ) u_holder (
      .clk         (clk),
      .rst_n       (rst_n),
      .clear_i     (clear_s),
      .valid_i     (valid_s[g]),
      .label_i     (in_label_s[g]),
      .last_i      (in_last_s[g]),
      .ready_o     (ready_s[g]),
      .full_o      (full_s[g]),
      .full_next_o (full_next_s[g]),
      .label_o     (label_s[g]),
      .last_o      (last_s[g])
    );
  end

  assign s_axis_tready_0 = ready_s[0];
  assign s_axis_tready_1 = ready_s[1];
  assign s_axis_tready_2 = ready_s[2];

  logic                   eq_ab_s, eq_ac_s, eq_bc_s;
  logic [CLASS_WIDTH-1:0] vote_label_s;
  logic [VOTE_CNT_W-1:0]  vote_cnt_s;

  // Majority vote over the held labels; TIE_SEL breaks a three-way split.
  always_comb begin
    eq_ab_s = (label_s[0] == label_s[1]);
    eq_ac_s = (label_s[0] == label_s[2]);
    eq_bc_s = (label_s[1] == label_s[2]);
    if (eq_ab_s || eq_ac_s) begin
      vote_label_s = label_s[0];
    end else if (eq_bc_s) begin
      vote_label_s = label_s[1];
    end else begin
      vote_label_s = label_s[TIE_SEL];
    end
    if (eq_ab_s && eq_bc_s) begin
      vote_cnt_s = 2'd3;
    end else if (eq_ab_s || eq_ac_s || eq_bc_s) begin
      vote_cnt_s = 2'd2;
    end else begin
      vote_cnt_s = 2'd1;
    end
  end

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                  tlast_q, tlast_d;
  logic                  tvalid_q, tvalid_d;
  logic                  mism_q, mism_d;
  logic [31:0]           rcount_q, rcount_d;
  logic [15:0]           dcount_q, dcount_d;

  // Next-state and result/counter updates.
  always_comb begin
    state_d  = state_q;
    tdata_d  = tdata_q;
    tlast_d  = tlast_q;
    tvalid_d = tvalid_q;
    mism_d   = mism_q;
    rcount_d = rcount_q;
    dcount_d = dcount_q;
    clear_s  = 1'b0;
    case (state_q)
      COLLECT: begin
        if (&full_s) begin
          state_d = VOTE;
        end else begin
          state_d = COLLECT;
        end
      end
      VOTE: begin
        tdata_d = {DATA_WIDTH{1'b0}};
        tdata_d[VOTE_CNT_LSB +: VOTE_CNT_W] = vote_cnt_s;
        tdata_d[CLASS_WIDTH-1:0] = vote_label_s;
        tlast_d = |last_s;
        if (!((&last_s) || !(|last_s))) begin
          mism_d = 1'b1;
        end else begin
          mism_d = mism_q;
        end
        clear_s  = 1'b1;
        tvalid_d = 1'b1;
        state_d  = SEND;
      end
      SEND: begin
        if (tvalid_q && m_axis_tready) begin
          tvalid_d = 1'b0;
          rcount_d = rcount_q + 32'd1;
          if ((tdata_q[VOTE_CNT_LSB +: VOTE_CNT_W] != 2'd3) && (dcount_q != 16'hFFFF)) begin
            dcount_d = dcount_q + 16'd1;
          end else begin
            dcount_d = dcount_q;
          end
          // Lanes refilled on this same edge let the next vote start immediately.
          if (&full_next_s) begin
            state_d = VOTE;
          end else begin
            state_d = COLLECT;
          end
        end else begin
          state_d = SEND;
        end
      end
      default: begin
        state_d  = COLLECT;
        tvalid_d = 1'b0;
      end
    endcase
  end

  // State, result and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= COLLECT;
      tdata_q  <= {DATA_WIDTH{1'b0}};
      tlast_q  <= 1'b0;
      tvalid_q <= 1'b0;
      mism_q   <= 1'b0;
      rcount_q <= 32'd0;
      dcount_q <= 16'd0;
    end else begin
      state_q  <= state_d;
      tdata_q  <= tdata_d;
      tlast_q  <= tlast_d;
      tvalid_q <= tvalid_d;
      mism_q   <= mism_d;
      rcount_q <= rcount_d;
      dcount_q <= dcount_d;
    end
  end

  assign m_axis_tdata   = tdata_q;
  assign m_axis_tkeep   = {KEEP_WIDTH{1'b1}};
  assign m_axis_tvalid  = tvalid_q;
  assign m_axis_tlast   = tlast_q;
  assign result_count   = rcount_q;
  assign disagree_count = dcount_q;
  assign tlast_mismatch = mism_q;

endmodule
